id_responder: RTL and testbench
===============================

ID_RESPONDER -- requirements
Module: id_responder

Interface
REQ-001 SHALL have parameter ID_NUM, default 1, instance address 0..254 (255 reserved for broadcast).
REQ-002 SHALL have parameter VERSION, default 1, 8-bit version byte returned in every response.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_i  input  1  serial query line, idle high, one bit per clk.
REQ-006 SHALL have port tx_o  output  1  serial response line, idle high, one bit per clk.
REQ-007 SHALL have port tx_en_o  output  1  high exactly while a response frame is driven on tx_o.
REQ-008 SHALL have port hit_o  output  1  one-cycle pulse when a valid query addresses this instance.
REQ-009 SHALL have port err_o  output  1  one-cycle pulse on query framing error.

Function
REQ-010 SHALL implement states IDLE, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP.
REQ-011 SHALL leave IDLE for RX_DATA when rx_i is sampled 0 (start bit); otherwise stay in IDLE.
REQ-012 SHALL in RX_DATA capture 8 consecutive rx_i samples LSB-first into a command byte using a 4-bit bit counter, then enter RX_STOP.
REQ-013 SHALL in RX_STOP, if rx_i=0, pulse err_o for one cycle and return to IDLE without responding.
REQ-014 SHALL in RX_STOP, if rx_i=1 and command equals ID_NUM or 8'hFF, enter TURN; otherwise return to IDLE silently.
REQ-015 SHALL assert hit_o only during the single TURN cycle, with tx_o=1 and tx_en_o=0.
REQ-016 SHALL in TX_START drive tx_o=0 for one cycle.
REQ-017 SHALL in TX_DATA drive 16 bits: ID_NUM[7:0] LSB-first, then VERSION[7:0] LSB-first.
REQ-018 SHALL in TX_STOP drive tx_o=1 for one cycle, then return to IDLE.
REQ-019 SHALL hold tx_en_o high from TX_START through TX_STOP inclusive (18 cycles), low otherwise.
REQ-020 SHALL produce the response start bit exactly 2 cycles after the edge sampling the query stop bit.
REQ-021 SHALL ignore rx_i in TURN, TX_START, TX_DATA, TX_STOP; a query overlapping a response is lost.
REQ-022 SHALL accept a new start bit in the first IDLE cycle after TX_STOP or RX_STOP (back-to-back queries supported).
REQ-023 SHALL register tx_o, tx_en_o, hit_o and err_o (no combinational path from rx_i).
REQ-024 SHALL never assert hit_o and err_o in the same cycle.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE, bit counter 0, command byte 0, tx_o=1, tx_en_o=0, hit_o=0, err_o=0.
REQ-026 SHALL abort any query or response in progress when reset asserts mid-frame; after release, wait for a fresh start bit.

Structure
REQ-027 SHALL take state encodings, BCAST_ID=8'hFF, CMD_W=8 and RESP_BITS=16 from shared package id_proto_pkg.
REQ-028 SHALL place query deserialisation (start detect, 8-bit shift, stop check) in sub-module id_frame_rx, with the response FSM and shifter in id_responder.

Verification
REQ-029 SHALL cover: ID_NUM=2, VERSION=4, query 8'h02 with good stop -> hit_o pulse, then tx_o = 0, 0x02 LSB-first, 0x04 LSB-first, 1; tx_en_o high 18 cycles.
REQ-030 SHALL cover: query 8'h03 to ID_NUM=2 -> no hit_o, tx_en_o stays 0, tx_o stays 1.
REQ-031 SHALL cover: query 8'hFF to ID_NUM=3 and ID_NUM=99 instances sharing rx_i -> both respond with their own ID byte, same cycle timing.
REQ-032 SHALL cover: query 8'h02 with stop bit 0 -> err_o single pulse, no response, next good query answered.
REQ-033 SHALL cover: rst_n low at TX_DATA bit 5 -> tx_o=1, tx_en_o=0 asynchronously; no resumption after release.
REQ-034 SHALL cover: two matching queries back-to-back, second start bit during first response -> only first answered; query after TX_STOP answered.

Source files
------------

// File: rtl/id_proto_pkg.sv
// Protocol constants and the shared state encoding for the ID query/response link.
package id_proto_pkg;

  localparam int CMD_W     = 8;
  localparam int RESP_BITS = 16;
  localparam logic [CMD_W-1:0] BCAST_ID = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    RX_DATA,
    RX_STOP,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_t;

  // True when a received command targets the given instance address or broadcast.
  function automatic logic addressed(input logic [CMD_W-1:0] cmd,
                                     input logic [CMD_W-1:0] id);
    return (cmd == id) || (cmd == BCAST_ID);
  endfunction

endpackage

// File: rtl/id_responder_if.sv
// Serial query/response line bundle: the tester drives rx, the responder drives the rest.
interface id_responder_if;

  logic rx;
  logic tx;
  logic tx_en;
  logic hit;
  logic err;

  modport master (output rx, input tx, tx_en, hit, err);
  modport slave  (input rx, output tx, tx_en, hit, err);

endinterface

// File: rtl/id_frame_rx.sv
// Query deserialiser: start detect, 8-bit LSB-first shift, then stop-bit check.
module id_frame_rx
  import id_proto_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             enable,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CMD_W-1:0] cmd
);

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CMD_W-1:0] cmd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cmd       <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd       <= cmd_d;
    end
  end

  // The responder withholds enable while it owns the line, so queries overlapping a response are lost.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd;
    case (state_q)
      IDLE: begin
        if (enable && !rx) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        cmd_d = {rx, cmd[CMD_W-1:1]};
        if (bit_cnt_q == 4'(CMD_W - 1)) begin
          state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      RX_STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_done = (state_q == RX_STOP) && rx;
  assign frame_err  = (state_q == RX_STOP) && !rx;

endmodule

// File: rtl/id_responder.sv
// Addressable ID responder: answers a matching serial query with a start bit, ID byte, VERSION byte and stop bit.
module id_responder
  import id_proto_pkg::*;
#(
  parameter int unsigned ID_NUM  = 1,
  parameter logic [7:0]  VERSION = 8'd1
)(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic tx_o,
  output logic tx_en_o,
  output logic hit_o,
  output logic err_o
);

  localparam logic [CMD_W-1:0] MY_ID = CMD_W'(ID_NUM);

  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [RESP_BITS-1:0]   shift_q, shift_d;
  logic                   tx_d, tx_en_d, hit_d, err_d;
  logic                   frame_done, frame_err;
  logic [CMD_W-1:0]       cmd;

  id_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx_i),
    .enable     (state_q == IDLE),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .cmd        (cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_o      <= 1'b1;
      tx_en_o   <= 1'b0;
      hit_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_o      <= tx_d;
      tx_en_o   <= tx_en_d;
      hit_o     <= hit_d;
      err_o     <= err_d;
    end
  end

  // Outputs are computed for the state being entered, so each registered output lines up with its state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    tx_en_d   = 1'b0;
    hit_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_err) begin
          err_d = 1'b1;
        end else if (frame_done && addressed(cmd, MY_ID)) begin
          state_d = TURN;
          hit_d   = 1'b1;
        end
      end
      TURN: begin
        state_d   = TX_START;
        tx_d      = 1'b0;
        tx_en_d   = 1'b1;
        shift_d   = {VERSION, MY_ID};
        bit_cnt_d = '0;
      end
      TX_START: begin
        state_d = TX_DATA;
        tx_d    = shift_q[0];
        tx_en_d = 1'b1;
        shift_d = {1'b0, shift_q[RESP_BITS-1:1]};
      end
      TX_DATA: begin
        tx_en_d = 1'b1;
        if (bit_cnt_q == 4'(RESP_BITS - 1)) begin
          state_d = TX_STOP;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[RESP_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      TX_STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_id_responder.sv
// Scoreboard bench: three id_responder instances (IDs 2, 3, 99) share one query line.
module tb_id_responder;

  localparam int NDUT = 3;
  localparam logic [1:0] K_HIT   = 2'd0;
  localparam logic [1:0] K_ERR   = 2'd1;
  localparam logic [1:0] K_FRAME = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  dut;
    logic [31:0] cyc;
    logic [17:0] bits;
    logic [7:0]  len;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rx    = 1'b1;
  int   cyc   = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   both_cnt   = 0;
  int   glitch_cnt = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];

  id_responder_if bus2 ();
  id_responder_if bus3 ();
  id_responder_if bus99 ();

  assign bus2.rx  = rx;
  assign bus3.rx  = rx;
  assign bus99.rx = rx;

  id_responder #(.ID_NUM(2), .VERSION(8'h04)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_i(bus2.rx), .tx_o(bus2.tx),
    .tx_en_o(bus2.tx_en), .hit_o(bus2.hit), .err_o(bus2.err)
  );
  id_responder #(.ID_NUM(3), .VERSION(8'h30)) dut3 (
    .clk(clk), .rst_n(rst_n), .rx_i(bus3.rx), .tx_o(bus3.tx),
    .tx_en_o(bus3.tx_en), .hit_o(bus3.hit), .err_o(bus3.err)
  );
  id_responder #(.ID_NUM(99), .VERSION(8'hA5)) dut99 (
    .clk(clk), .rst_n(rst_n), .rx_i(bus99.rx), .tx_o(bus99.tx),
    .tx_en_o(bus99.tx_en), .hit_o(bus99.hit), .err_o(bus99.err)
  );

  logic [NDUT-1:0] tx_v, tx_en_v, hit_v, err_v;
  assign tx_v    = {bus99.tx, bus3.tx, bus2.tx};
  assign tx_en_v = {bus99.tx_en, bus3.tx_en, bus2.tx_en};
  assign hit_v   = {bus99.hit, bus3.hit, bus2.hit};
  assign err_v   = {bus99.err, bus3.err, bus2.err};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dut_id(input int i);
    case (i)
      0:       return 8'd2;
      1:       return 8'd3;
      default: return 8'd99;
    endcase
  endfunction

  function automatic logic [7:0] dut_ver(input int i);
    case (i)
      0:       return 8'h04;
      1:       return 8'h30;
      default: return 8'hA5;
    endcase
  endfunction

  function automatic rec_t mk(input logic [1:0] kind, input int dut, input int c,
                              input logic [17:0] bits, input int len);
    rec_t r;
    r.kind = kind;
    r.dut  = 2'(dut);
    r.cyc  = 32'(c);
    r.bits = bits;
    r.len  = 8'(len);
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("kind=%0d dut=%0d cyc=%0d bits=%05h len=%0d",
                     r.kind, r.dut, r.cyc, r.bits, r.len);
  endfunction

  // Observer: logs hit/err pulses and whole tx_en frames; an in-flight frame is dropped on reset.
  initial begin
    int cur_len[NDUT];
    int cur_start[NDUT];
    logic [17:0] cur_bits[NDUT];
    for (int i = 0; i < NDUT; i++) begin
      cur_len[i] = 0; cur_start[i] = 0; cur_bits[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (!rst_n) begin
          cur_len[i] = 0;
        end else begin
          if (hit_v[i]) obs_q.push_back(mk(K_HIT, i, cyc, '0, 0));
          if (err_v[i]) obs_q.push_back(mk(K_ERR, i, cyc, '0, 0));
          if (hit_v[i] && err_v[i]) both_cnt++;
          if (!tx_en_v[i] && tx_v[i] !== 1'b1) glitch_cnt++;
          if (tx_en_v[i]) begin
            if (cur_len[i] == 0) begin
              cur_start[i] = cyc;
              cur_bits[i]  = '0;
            end
            if (cur_len[i] < 18) cur_bits[i][cur_len[i]] = tx_v[i];
            cur_len[i]++;
          end else if (cur_len[i] != 0) begin
            obs_q.push_back(mk(K_FRAME, i, cur_start[i], cur_bits[i], cur_len[i]));
            cur_len[i] = 0;
          end
        end
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB-first and the stop bit; s returns the stop-bit cycle.
  task automatic send_query(input logic [7:0] cmd, input logic stop, output int s);
    rx = 1'b0;
    @(posedge clk); #1;
    for (int b = 0; b < 8; b++) begin
      rx = cmd[b];
      @(posedge clk); #1;
    end
    rx = stop;
    s  = cyc;
    @(posedge clk); #1;
    rx = 1'b1;
  endtask

  // Reference model: every idle instance sees the query; events land 1 and 2 cycles after the stop bit.
  task automatic expect_query(input logic [7:0] cmd, input logic stop, input int s);
    for (int i = 0; i < NDUT; i++) begin
      if (!stop) exp_q.push_back(mk(K_ERR, i, s + 1, '0, 0));
      else if (cmd == dut_id(i) || cmd == 8'hFF) exp_q.push_back(mk(K_HIT, i, s + 1, '0, 0));
    end
    for (int i = 0; i < NDUT; i++) begin
      if (stop && (cmd == dut_id(i) || cmd == 8'hFF))
        exp_q.push_back(mk(K_FRAME, i, s + 2, {1'b1, dut_ver(i), dut_id(i), 1'b0}, 18));
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < NDUT; i++) begin
      got = {tx_v[i], tx_en_v[i], hit_v[i], err_v[i]};
      n_checks++;
      if (got !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs dut%0d: got tx/en/hit/err=%b, expected 1000", i, got);
      end
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    settle(5);
    n_checks++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %0d events, expected 0", obs_q.size());
    end
  endtask

  task automatic test_match();
    int s;
    rec_t e, o;
    send_query(8'h02, 1'b1, s);
    expect_query(8'h02, 1'b1, s);
    settle(25);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL match_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL match_event: got %s, expected %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_no_match();
    int s;
    rec_t e, o;
    send_query(8'h03, 1'b1, s);
    expect_query(8'h03, 1'b1, s);
    settle(25);
    send_query(8'h00, 1'b1, s);
    expect_query(8'h00, 1'b1, s);
    settle(25);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL nomatch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL nomatch_event: got %s, expected %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_broadcast();
    int s;
    rec_t e, o;
    send_query(8'hFF, 1'b1, s);
    expect_query(8'hFF, 1'b1, s);
    settle(25);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL bcast_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL bcast_event: got %s, expected %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_stop_error();
    int s1, s2;
    rec_t e, o;
    send_query(8'h02, 1'b0, s1);
    expect_query(8'h02, 1'b0, s1);
    send_query(8'h02, 1'b1, s2);
    expect_query(8'h02, 1'b1, s2);
    settle(25);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL stoperr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL stoperr_event: got %s, expected %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    int s;
    rec_t e, o;
    send_query(8'h02, 1'b1, s);
    exp_q.push_back(mk(K_HIT, 0, s + 1, '0, 0));
    while (cyc < s + 8) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if ({bus2.tx_en, bus2.tx} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL midtx_bit5: got tx_en/tx=%b%b, expected 10", bus2.tx_en, bus2.tx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus2.tx, bus2.tx_en, bus2.hit, bus2.err} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL midtx_async_reset: got tx/en/hit/err=%b%b%b%b, expected 1000",
               bus2.tx, bus2.tx_en, bus2.hit, bus2.err);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    settle(30);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL midtx_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL midtx_event: got %s, expected %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, s3;
    rec_t e, o;
    send_query(8'h02, 1'b1, s1);
    expect_query(8'h02, 1'b1, s1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    send_query(8'h02, 1'b1, s2);
    while (cyc < s1 + 20) begin
      @(posedge clk); #1;
    end
    send_query(8'h02, 1'b1, s3);
    expect_query(8'h02, 1'b1, s3);
    settle(25);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = '1; o = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("[TB] FAIL b2b_event: got %s, expected %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL hit_err_overlap: got %0d cycles, expected 0", both_cnt);
    end
    n_checks++;
    if (glitch_cnt !== 0) begin
      n_fail++;
      $display("[TB] FAIL tx_idle_level: got %0d cycles with tx low outside a frame, expected 0", glitch_cnt);
    end
  endtask

  initial begin
    $display("[TB] id_responder bench starting");
    test_reset();
    test_match();
    test_no_match();
    test_broadcast();
    test_stop_error();
    test_reset_mid_tx();
    test_back_to_back();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
